// File: rtl/algo_sva_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : algo_sva_chk_pkg
// Purpose  : Shared types and helpers for the 1r6w a112 select-address
//            checker. It holds the read-pipeline entry flags, the helper that
//            picks the highest-index write port that matches, and the
//            saturating adder used by the error counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package algo_sva_chk_pkg;

  // The widest write-port vector the priority helper accepts.
  localparam int C_MAX_PORTS = 32;

  // Flag part of a read-pipeline entry. The expected data word is appended in
  // the top, where WIDTH is known.
  typedef struct packed {
    logic v;      // a read was issued in this slot
    logic hit;    // the read targeted the selected address
    logic known;  // the shadow held a valid value when the read was issued
  } ent_flags_t;

  // Returns the index of the highest set bit. The result is 0 when the mask is
  // empty, so callers qualify it with a non-empty mask.
  function automatic logic [4:0] hi_index(input logic [C_MAX_PORTS-1:0] mask);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < C_MAX_PORTS; i++) begin
      if (mask[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  // Adds inc to a and clamps the result at cmax. The sum is formed one bit
  // wider so that it cannot wrap before the clamp is applied.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [1:0]  inc,
                                          input logic [31:0] cmax);
    logic [32:0] s;
    s = {1'b0, a} + {31'd0, inc};
    return (s > {1'b0, cmax}) ? cmax : s[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/algo_sva_delay_pipe.sv
`default_nettype none
// ============================================================================
// Module   : algo_sva_delay_pipe
// Purpose  : A fixed-depth shift register that delays a packed read entry by
//            DEPTH clock cycles. It shifts on every cycle.
// Ports    : clk  - clock
//            rst  - asynchronous reset, active low; clears every stage to 0
//            i_d  - entry pushed into the first stage
//            o_q  - entry leaving the last stage (DEPTH cycles old)
// Revision : 1.0 - initial release
// ============================================================================
module algo_sva_delay_pipe #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 35
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/algo_1r6w_a112_sva_selchk.sv
`default_nettype none
// ============================================================================
// Module   : algo_1r6w_a112_sva_selchk
// Purpose  : Data-integrity checker for one selected address of a 1r6w
//            memory. The six write ports update a shadow copy of that
//            address. The expected value of each read is delayed by
//            READ_DELAY cycles and then compared with rd_dout and rd_vld. The
//            block reports miscompares, valid-protocol errors and illegal
//            addresses, and keeps a sticky flag and a saturating error count.
// Ports    : clk, rst (async, active low)
//            ready                       - memory ready; stimulus is ignored at 0
//            select_addr                 - address under check (locked on the
//                                          first ready cycle)
//            write/wr_adr/din            - six write ports, packed by port
//            read/rd_adr                 - read request
//            rd_vld/rd_dout/rd_serr/rd_derr - memory read response
//            shadow_vld/shadow_dat       - shadow copy of the selected address
//            chk_mismatch/chk_vld_err/chk_adr_err - registered error pulses
//            chk_sticky/err_cnt          - accumulated error status
// Revision : 1.0 - initial release
// ============================================================================
module algo_1r6w_a112_sva_selchk
  import algo_sva_chk_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int NUMADDR    = 8192,
  parameter int BITADDR    = 13,
  parameter int NUMWRPT    = 6,
  parameter int READ_DELAY = 4,
  parameter int BITCNT     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ready,
  input  logic [BITADDR-1:0]         select_addr,
  input  logic [NUMWRPT-1:0]         write,
  input  logic [NUMWRPT*BITADDR-1:0] wr_adr,
  input  logic [NUMWRPT*WIDTH-1:0]   din,
  input  logic                       read,
  input  logic [BITADDR-1:0]         rd_adr,
  input  logic                       rd_vld,
  input  logic [WIDTH-1:0]           rd_dout,
  input  logic                       rd_serr,
  input  logic                       rd_derr,
  output logic                       shadow_vld,
  output logic [WIDTH-1:0]           shadow_dat,
  output logic                       chk_mismatch,
  output logic                       chk_vld_err,
  output logic                       chk_adr_err,
  output logic                       chk_sticky,
  output logic [BITCNT-1:0]          err_cnt
);

  localparam logic [31:0] C_NUMADDR = 32'(NUMADDR);
  localparam logic [31:0] C_CNT_MAX = 32'((64'd1 << BITCNT) - 64'd1);

  typedef struct packed {
    ent_flags_t       f;
    logic [WIDTH-1:0] exp;
  } ent_t;

  logic               r_sel_lk;
  logic [BITADDR-1:0] r_sel_q;
  logic               r_shadow_vld;
  logic [WIDTH-1:0]   r_shadow_dat;
  logic               r_mis, r_vld_err, r_adr_err, r_sticky;
  logic [BITCNT-1:0]  r_cnt;

  logic [BITADDR-1:0] w_sel;
  logic [NUMWRPT-1:0] w_wr_hit, w_wr_bad;
  logic [4:0]         w_hi_idx;
  logic [WIDTH-1:0]   w_hi_dat;
  logic               w_rd_bad;
  ent_t               w_push_ent, w_tail;
  logic [$bits(ent_t)-1:0] w_push_vec, w_tail_vec;
  logic               w_mis, w_vld_err, w_adr_err;
  logic               w_unused_serr;

  // Before the lock, the live select_addr is used directly. This lets the
  // first ready cycle already track the address it is about to lock.
  assign w_sel = r_sel_lk ? r_sel_q : select_addr;

  // Decode each write port. Out-of-range addresses never match, so an illegal
  // write cannot update the shadow.
  for (genvar gi = 0; gi < NUMWRPT; gi++) begin : g_wr
    logic [BITADDR-1:0] w_adr;
    logic               w_ok;
    assign w_adr        = wr_adr[gi*BITADDR +: BITADDR];
    assign w_ok         = 32'(w_adr) < C_NUMADDR;
    assign w_wr_hit[gi] = write[gi] && w_ok && (w_adr == w_sel);
    assign w_wr_bad[gi] = write[gi] && !w_ok;
  end

  // On a multi-port collision at the selected address, the highest port wins.
  assign w_hi_idx = hi_index(C_MAX_PORTS'(w_wr_hit));
  assign w_hi_dat = din[w_hi_idx*WIDTH +: WIDTH];
  assign w_rd_bad = read && !(32'(rd_adr) < C_NUMADDR);

  // The read samples the shadow before this cycle's writes land, which gives
  // read-old semantics on a same-cycle read/write.
  always_comb begin
    w_push_ent = '0;
    if (ready && read) begin
      w_push_ent.f.v     = 1'b1;
      w_push_ent.f.hit   = (rd_adr == w_sel);
      w_push_ent.f.known = r_shadow_vld;
      w_push_ent.exp     = r_shadow_dat;
    end
  end

  assign w_push_vec = w_push_ent;
  assign w_tail     = ent_t'(w_tail_vec);

  algo_sva_delay_pipe #(
    .DEPTH (READ_DELAY),
    .WIDTH ($bits(ent_t))
  ) u_pipe (
    .clk (clk),
    .rst (rst),
    .i_d (w_push_vec),
    .o_q (w_tail_vec)
  );

  // A single-bit error has already been corrected, so it does not gate the
  // compare. Only an uncorrectable error suppresses the compare.
  assign w_unused_serr = rd_serr;
  assign w_vld_err = (w_tail.f.v != rd_vld);
  assign w_mis     = w_tail.f.v && rd_vld && w_tail.f.hit && w_tail.f.known &&
                     !rd_derr && (rd_dout != w_tail.exp);
  assign w_adr_err = ready && (w_rd_bad || (|w_wr_bad));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel_lk     <= 1'b0;
      r_sel_q      <= '0;
      r_shadow_vld <= 1'b0;
      r_shadow_dat <= '0;
      r_mis        <= 1'b0;
      r_vld_err    <= 1'b0;
      r_adr_err    <= 1'b0;
      r_sticky     <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_mis     <= w_mis;
      r_vld_err <= w_vld_err;
      r_adr_err <= w_adr_err;
      // The sticky flag rises together with the first pulse. The counter
      // accumulates the registered pulses on the following cycle.
      r_sticky  <= r_sticky | w_mis | w_vld_err | w_adr_err;
      r_cnt     <= BITCNT'(sat_add(32'(r_cnt),
                                   {1'b0, r_mis} + {1'b0, r_vld_err} + {1'b0, r_adr_err},
                                   C_CNT_MAX));
      if (ready) begin
        if (!r_sel_lk) begin
          r_sel_q  <= select_addr;
          r_sel_lk <= 1'b1;
        end
        if (|w_wr_hit) begin
          r_shadow_vld <= 1'b1;
          r_shadow_dat <= w_hi_dat;
        end
      end
    end
  end

  assign shadow_vld   = r_shadow_vld;
  assign shadow_dat   = r_shadow_dat;
  assign chk_mismatch = r_mis;
  assign chk_vld_err  = r_vld_err;
  assign chk_adr_err  = r_adr_err;
  assign chk_sticky   = r_sticky;
  assign err_cnt      = r_cnt;

endmodule
`default_nettype wire

// File: doc/algo_1r6w_a112_sva_selchk.md
Name: algo_1r6w_a112_sva_selchk

Overview:
- Downstream consumer of the 1r6w a112 memory read path: a select-address data-integrity checker bound next to the memory's SVA wrap.
- Keeps a shadow copy of one selected address, updated by the six write ports.
- Pipelines the expected value of each read to the fixed read latency, then compares it against rd_dout/rd_vld.
- Reports mismatches, valid-protocol errors and a saturating error count, for formal and simulation closure.

Parameters:
- WIDTH, 32, data width per port
- NUMADDR, 8192, number of logical addresses
- BITADDR, 13, address width
- NUMWRPT, 6, write ports
- READ_DELAY, 4, cycles from read to rd_vld (>=1; set to SRAM_DELAY+DRAM_DELAY+flop stages of the memory)
- BITCNT, 16, error counter width

Ports:
- clk, in, 1, clock
- rst, in, 1, asynchronous active-low reset (asserted at 0)
- ready, in, 1, memory ready; stimulus ignored while 0
- select_addr, in, BITADDR, address under check
- write, in, NUMWRPT, per-port write enable
- wr_adr, in, NUMWRPT*BITADDR, write addresses, port i at [i*BITADDR +: BITADDR]
- din, in, NUMWRPT*WIDTH, write data, port i at [i*WIDTH +: WIDTH]
- read, in, 1, read enable
- rd_adr, in, BITADDR, read address
- rd_vld, in, 1, memory read valid
- rd_dout, in, WIDTH, memory read data
- rd_serr, in, 1, single-bit error (corrected)
- rd_derr, in, 1, double-bit error (uncorrectable)
- shadow_vld, out, 1, selected address written since reset
- shadow_dat, out, WIDTH, shadow value
- chk_mismatch, out, 1, one-cycle pulse: data miscompare
- chk_vld_err, out, 1, one-cycle pulse: rd_vld disagrees with expected valid
- chk_adr_err, out, 1, one-cycle pulse: read or write address >= NUMADDR while ready
- chk_sticky, out, 1, OR of all error pulses since reset
- err_cnt, out, BITCNT, saturating count of error pulses

Behaviour:
- Reset (rst=0, async): all outputs 0, pipeline empty, sel_q=0, sel_lk=0.
- Select lock: on the first cycle with ready=1 after reset, sel_q<=select_addr and sel_lk<=1. Later select_addr changes are ignored until the next reset. Before the lock, the current select_addr is used combinationally for that cycle.
- Shadow update (ready=1): the match set is the ports i with write[i] && wr_adr_i==sel && wr_adr_i<NUMADDR.
  - If the set is non-empty: shadow_dat<=din of the highest-index matching port; shadow_vld<=1.
  - Same-address multi-port collision: the highest port wins.
- Read capture (ready=1, read=1): push entry {v=1, hit=(rd_adr==sel), known=shadow_vld, exp=shadow_dat} using pre-update shadow. A same-cycle write is not visible (read-old semantics).
- Otherwise push v=0. A read while ready=0 pushes v=0.
- Pipeline: READ_DELAY-deep shift register, shifts every cycle; the tail entry aligns with rd_vld of the same cycle.
- Valid check: chk_vld_err=1 when tail.v != rd_vld (missing or spurious valid).
- Data check: chk_mismatch=1 when all of the following hold:
  - tail.v, rd_vld, tail.hit, tail.known
  - !rd_derr
  - rd_dout != tail.exp
- rd_serr does not suppress the compare (data is corrected). rd_derr suppresses the compare.
- Address check: chk_adr_err=1 in the cycle of the offending read or write (registered, one-cycle latency). An offending write is not applied to the shadow.
- Error pulses are registered: they assert one cycle after the tail/stimulus cycle.
- err_cnt += (chk_mismatch + chk_vld_err + chk_adr_err) per cycle, saturating at all-ones, no wrap.
- chk_sticky sets on any pulse and clears only on reset.
- Reset mid-operation: pipeline flushed. rd_vld arriving after reset release for pre-reset reads is flagged as chk_vld_err.

Decomposition:
- Package algo_sva_chk_pkg: read-pipeline entry struct {v, hit, known, exp[WIDTH]}, helper function for highest-index match select, saturating-add function.
- One sub-module: algo_sva_delay_pipe (parameterised DEPTH/WIDTH, async active-low reset to 0, carries the packed entry).

Test Plan:
- Reset, ready=1, select_addr=0x0A5. Port 2 writes 0x1234_5678 to 0x0A5. Read 0x0A5 two cycles later; rd_vld at +4 with rd_dout=0x1234_5678 -> no errors, err_cnt=0. Same with rd_dout=0x1234_5679 -> chk_mismatch pulse, err_cnt=1, chk_sticky=1.
- Ports 1 and 5 write 0xAAAA_0001 and 0xBBBB_0005 to 0x0A5 in the same cycle -> shadow_dat=0xBBBB_0005. Read with rd_dout=0xBBBB_0005 -> clean.
- Read 0x0A5 in the same cycle that port 0 writes 0xCCCC_0000 (old value 0xBBBB_0005) -> expected 0xBBBB_0005. Returned 0xCCCC_0000 -> chk_mismatch.
- Read issued but rd_vld withheld at +4 -> chk_vld_err. rd_vld=1 with no read at -4 -> chk_vld_err. rd_derr=1 with wrong data -> no mismatch. rd_serr=1 with wrong data -> mismatch.
- Write to address 8192 (beyond NUMADDR) with an 14-bit test override, or read of an illegal address -> chk_adr_err, shadow unchanged. Force 65536 errors -> err_cnt holds 0xFFFF.
- Reads in flight, rst pulsed low for 1 cycle -> outputs 0. Stale rd_vld after release -> chk_vld_err. select_addr changed after lock -> checking continues on the original address.
